mac_accum: RTL
==============

MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL provide parameter ACC_W, default 12, meaning accumulator and result width in bits (legal 8..16).
REQ-002 SHALL provide parameter N_TERMS, default 4, meaning number of products summed per result (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port prod  input  8  signed two's-complement product from the upstream 4x4 booth multiplier.
REQ-006 SHALL have port prod_valid  input  1  prod is valid this cycle.
REQ-007 SHALL have port prod_ready  output  1  block accepts prod this cycle.
REQ-008 SHALL have port acc_clear  input  1  synchronous abort of the current sum.
REQ-009 SHALL have port res  output  ACC_W  signed accumulated result.
REQ-010 SHALL have port res_sat  output  1  at least one saturation occurred in this result.
REQ-011 SHALL have port res_valid  output  1  res and res_sat are valid.
REQ-012 SHALL have port res_ready  input  1  downstream accepts res this cycle.
REQ-013 SHALL have port count  output  4  number of products accepted into the current sum.

Function
REQ-014 SHALL implement three states: IDLE, ACC and HOLD.
REQ-015 SHALL accept a product only when prod_valid and prod_ready are both 1 at a rising clk edge.
REQ-016 SHALL drive prod_ready=1 in IDLE and ACC, and 0 in HOLD and during any cycle in which rst is 1.
REQ-017 SHALL, on an accepted product in IDLE, set acc to the sign-extended prod and count to 1, then go to ACC (or to HOLD when N_TERMS=1).
REQ-018 SHALL, on an accepted product in ACC, set acc to sat(acc + sign-extended prod) and increment count.
REQ-019 SHALL compute the sum at ACC_W+1 bits and clamp it to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow, setting the sticky flag sat.
REQ-020 SHALL enter HOLD on the edge that accepts the N_TERMS-th product, so res_valid is 1 in the following cycle (1-cycle latency).
REQ-021 SHALL hold res=acc, res_sat=sat, res_valid=1 and count=N_TERMS stable in HOLD until res_valid and res_ready are both 1 at an edge.
REQ-022 SHALL, on the HOLD handshake, return to IDLE with acc=0, sat=0, count=0 and res_valid=0 in the next cycle.
REQ-023 SHALL ignore prod_valid while prod_ready=0, without losing or altering any state.
REQ-024 SHALL ignore res_ready while res_valid=0.
REQ-025 SHALL, when acc_clear=1, go to IDLE with acc=0, sat=0, count=0 and res_valid=0 from any state, discarding any coincident product or pending result.
REQ-026 SHALL give acc_clear priority over a product handshake and over a result handshake.
REQ-027 SHALL drive res=acc and res_sat=sat in IDLE and ACC; these values are don't-care for the consumer while res_valid=0.

Reset
REQ-028 SHALL, while rst=1 at an edge, go to IDLE with acc=0, sat=0 and count=0, so that res=0, res_sat=0, res_valid=0 and count=0 in the next cycle.
REQ-029 SHALL give rst priority over acc_clear and over all handshakes, including when asserted mid-ACC or in HOLD.
REQ-030 SHALL drive prod_ready=1 in the first cycle in which rst=0.

Verification
REQ-031 SHALL pass this scenario at defaults: accept products 14, 15, 24 and 0 with res_ready=1 -> res=53 (0x035), res_sat=0, res_valid high for exactly 1 cycle, one cycle after the 4th product.
REQ-032 SHALL pass this scenario at ACC_W=8: accept four products of 64 -> res=127, res_sat=1; then accept four products of -56 -> res=-128 (0x80), res_sat=1.
REQ-033 SHALL pass this backpressure scenario: complete a result with res_ready=0 for 5 cycles, driving prod_valid=1 with prod=9 throughout -> res stable, prod_ready=0, count=4, no product absorbed; raise res_ready -> IDLE next cycle.
REQ-034 SHALL pass this abort scenario: accept 2 products (2 and 3), then assert acc_clear together with a valid product 5 -> count=0 next cycle; a following sum of 1, 1, 1, 1 gives res=4.
REQ-035 SHALL pass this reset scenario: assert rst in HOLD (res_valid=1) while res_ready=1 -> all outputs 0 next cycle with no handshake completed; prod_ready=1 one cycle after rst falls.
REQ-036 SHALL pass this degenerate-case scenario at N_TERMS=1: accept product -7 -> res=-7 with res_valid=1 in the next cycle.

Source files
------------

// File: rtl/mac_accum.sv
// Saturating multiply-accumulate collector: sums N_TERMS signed products from the
// upstream booth multiplier and offers the result with a valid/ready handshake.
module mac_accum #(
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] res,
  output logic             res_sat,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       count
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  localparam logic [3:0] LAST = 4'(N_TERMS);
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic sat, sat_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] sum_clamped;
  logic                    ovf;
  logic                    prod_take;

  // One guard bit is enough to detect overflow of a single addition; the clamp
  // direction follows the sign of the wide sum.
  always_comb begin
    prod_ext    = ACC_W'($signed(prod));
    sum         = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    ovf         = (sum[ACC_W] != sum[ACC_W-1]);
    sum_clamped = sum[ACC_W-1:0];
    if (ovf) begin
      sum_clamped = sum[ACC_W] ? MINV : MAXV;
    end
  end

  assign prod_ready = (state != HOLD) && !rst;
  assign prod_take  = prod_valid && prod_ready;
  assign res        = acc;
  assign res_sat    = sat;
  assign res_valid  = (state == HOLD);
  assign count      = cnt;

  // acc_clear outranks both handshakes; rst outranks everything in the register.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    sat_nxt   = sat;
    cnt_nxt   = cnt;
    if (acc_clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      sat_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (prod_take) begin
            acc_nxt   = prod_ext;
            sat_nxt   = 1'b0;
            cnt_nxt   = 4'd1;
            state_nxt = (LAST == 4'd1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (prod_take) begin
            acc_nxt = sum_clamped;
            sat_nxt = sat | ovf;
            cnt_nxt = cnt + 4'd1;
            if ((cnt + 4'd1) == LAST) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            sat_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          sat_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sat   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      sat   <= sat_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
